// File: rtl/dvp_stream_capture.sv
// -----------------------------------------------------------------------------
// dvp_stream_capture
//
// Front end of the ping-pong frame buffer write path. Takes a DVP camera bus
// (already synchronous to i_wclk), packs byte pairs into RGB444 pixels and
// presents them as an AXI-Stream with o_m_last on the final pixel of a frame.
// A small output FIFO rides out downstream backpressure. Every frame that has
// produced at least one beat is closed by exactly one last beat; truncated or
// overflowed frames are closed by a zero filler beat with last set.
//
// Ports
//   i_wclk        write-side clock
//   i_wrstn       synchronous active-low reset
//   i_vsync       frame sync, active high
//   i_href        line valid, active high
//   i_pix_en      byte strobe, i_pdata is only looked at when high
//   i_pdata[7:0]  camera byte (phase 0: R in [3:0]; phase 1: {G,B})
//   i_tp_sel      test pattern select, latched at vsync fall
//                 (present only with DVP_TEST_PATTERN_EN)
//   o_m_valid     AXI-S valid
//   i_m_ready     AXI-S ready
//   o_m_data      pixel {R[3:0],G[3:0],B[3:0]}
//   o_m_last      last beat of the frame
//   o_overflow    sticky: a pixel was dropped on a full FIFO
//   o_frame_err   sticky: a frame ended before its final pixel
//   i_clr_flags   one-cycle pulse clearing both sticky flags (a set wins)
//
// Build option
//   DVP_TEST_PATTERN_EN  adds i_tp_sel and an 8-bar colour pattern generator.
// -----------------------------------------------------------------------------
module dvp_stream_capture #(
   parameter int FRAME_WIDTH  = 320,
   parameter int FRAME_HEIGHT = 240,
   parameter int DATA_WIDTH   = 12,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  i_wclk,
   input  logic                  i_wrstn,
   input  logic                  i_vsync,
   input  logic                  i_href,
   input  logic                  i_pix_en,
   input  logic [7:0]            i_pdata,
`ifdef DVP_TEST_PATTERN_EN
   input  logic                  i_tp_sel,
`endif
   output logic                  o_m_valid,
   input  logic                  i_m_ready,
   output logic [DATA_WIDTH-1:0] o_m_data,
   output logic                  o_m_last,
   output logic                  o_overflow,
   output logic                  o_frame_err,
   input  logic                  i_clr_flags
);

   localparam int COL_W = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
   localparam int ROW_W = $clog2(FRAME_HEIGHT + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(FRAME_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(FRAME_HEIGHT - 1);
   localparam logic [ROW_W-1:0] ROW_END   = ROW_W'(FRAME_HEIGHT);
   localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

   generate
      if (DATA_WIDTH != 12) begin : g_bad_data_width
         $error("dvp_stream_capture: only DATA_WIDTH=12 (RGB444) is supported");
      end
      if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
         $error("dvp_stream_capture: FIFO_DEPTH must be a power of 2 and at least 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      WAIT_VS = 3'd0,
      ARM     = 3'd1,
      ACTIVE  = 3'd2,
      FLUSH   = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t                state_r;
   state_t                state_next_s;

   logic                  vs_d_r;
   logic                  href_d_r;
   logic                  vs_rise_s;
   logic                  vs_fall_s;
   logic                  href_fall_s;

   logic                  phase_r;
   logic [3:0]            red_r;
   logic [COL_W-1:0]      col_r;
   logic                  col_full_r;   // line already delivered FRAME_WIDTH pixels
   logic [ROW_W-1:0]      row_r;
   logic                  pushed_any_r;

   logic                  byte_s;
   logic                  pix_keep_s;
   logic                  pix_last_s;
   logic [DATA_WIDTH-1:0] pix_data_s;

   logic                  pend_valid_r;
   logic [DATA_WIDTH-1:0] pend_data_r;
   logic                  pend_last_r;

   logic [DATA_WIDTH:0]   mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [PTR_W-1:0]      rd_next_s;
   logic [CNT_W-1:0]      count_r;
   logic [CNT_W-1:0]      count_next_s;
   logic [DATA_WIDTH:0]   head_s;

   logic                  pop_s;
   logic                  push_ok_s;
   logic                  fifo_push_s;
   logic [DATA_WIDTH-1:0] fifo_wdata_s;
   logic                  fifo_wlast_s;
   logic                  pend_push_s;
   logic                  ovf_set_s;
   logic                  ferr_set_s;

   logic                  o_m_valid_r;
   logic [DATA_WIDTH-1:0] o_m_data_r;
   logic                  o_m_last_r;
   logic                  overflow_r;
   logic                  frame_err_r;

`ifdef DVP_TEST_PATTERN_EN
   logic                  tp_r;
   logic [2:0]            bar_idx_s;

   function automatic logic [11:0] bar_color(input logic [2:0] idx);
      case (idx)
         3'd0:    bar_color = 12'hFFF;
         3'd1:    bar_color = 12'hFF0;
         3'd2:    bar_color = 12'h0FF;
         3'd3:    bar_color = 12'h0F0;
         3'd4:    bar_color = 12'hF0F;
         3'd5:    bar_color = 12'hF00;
         3'd6:    bar_color = 12'h00F;
         default: bar_color = 12'h000;
      endcase
   endfunction

   // col is always below FRAME_WIDTH for a kept pixel, so the bar index fits 3 bits
   assign bar_idx_s = 3'((32'(col_r) * 32'd8) / 32'(FRAME_WIDTH));

   // Pattern select is frozen for the whole frame at vsync fall
   always_ff @(posedge i_wclk) begin
      if (!i_wrstn) begin
         tp_r <= 1'b0;
      end else if (vs_fall_s) begin
         tp_r <= i_tp_sel;
      end
   end
`endif

   assign vs_rise_s   = i_vsync  & ~vs_d_r;
   assign vs_fall_s   = ~i_vsync & vs_d_r;
   assign href_fall_s = ~i_href  & href_d_r;

   assign byte_s     = (state_r == ACTIVE) && i_href && i_pix_en;
   // Pixels beyond the line width, or on a row past the frame, never reach the FIFO
   assign pix_keep_s = byte_s && phase_r && !col_full_r && (row_r < ROW_END);
   assign pix_last_s = (row_r == ROW_LAST) && (col_r == COL_LAST);

   assign pop_s     = o_m_valid_r && i_m_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept
   assign push_ok_s = (count_r != FIFO_FULL) || pop_s;

   // Packed pixel value: camera bytes, or the colour bars when selected
   always_comb begin
`ifdef DVP_TEST_PATTERN_EN
      if (tp_r) begin
         pix_data_s = bar_color(bar_idx_s);
      end else begin
         pix_data_s = {red_r, i_pdata};
      end
`else
      pix_data_s = {red_r, i_pdata};
`endif
   end

   // vsync/href history for edge detection
   always_ff @(posedge i_wclk) begin
      if (!i_wrstn) begin
         vs_d_r   <= 1'b0;
         href_d_r <= 1'b0;
      end else begin
         vs_d_r   <= i_vsync;
         href_d_r <= i_href;
      end
   end

   // Byte phase, red holding register and pixel/line counters
   always_ff @(posedge i_wclk) begin
      if (!i_wrstn) begin
         phase_r      <= 1'b0;
         red_r        <= 4'h0;
         col_r        <= {COL_W{1'b0}};
         col_full_r   <= 1'b0;
         row_r        <= {ROW_W{1'b0}};
         pushed_any_r <= 1'b0;
      end else begin
         if (state_r == ARM) begin
            phase_r    <= 1'b0;
            col_r      <= {COL_W{1'b0}};
            col_full_r <= 1'b0;
            row_r      <= {ROW_W{1'b0}};
         end else if (href_fall_s) begin
            phase_r    <= 1'b0;
            col_r      <= {COL_W{1'b0}};
            col_full_r <= 1'b0;
            if (row_r != ROW_END) begin
               row_r <= row_r + ROW_W'(1);
            end
         end else if (byte_s) begin
            if (!phase_r) begin
               red_r   <= i_pdata[3:0];
               phase_r <= 1'b1;
            end else begin
               phase_r <= 1'b0;
               // col saturates at the last column; the flag marks "line is full"
               if (!col_full_r) begin
                  if (col_r == COL_LAST) begin
                     col_full_r <= 1'b1;
                  end else begin
                     col_r <= col_r + COL_W'(1);
                  end
               end
            end
         end
         if (state_r == ARM) begin
            pushed_any_r <= 1'b0;
         end else if (pend_push_s) begin
            pushed_any_r <= 1'b1;
         end
      end
   end

   // One-cycle staging between the phase-1 byte and the FIFO push
   always_ff @(posedge i_wclk) begin
      if (!i_wrstn) begin
         pend_valid_r <= 1'b0;
         pend_data_r  <= {DATA_WIDTH{1'b0}};
         pend_last_r  <= 1'b0;
      end else begin
         pend_valid_r <= pix_keep_s;
         if (pix_keep_s) begin
            pend_data_r <= pix_data_s;
            pend_last_r <= pix_last_s;
         end
      end
   end

   // Frame state register
   always_ff @(posedge i_wclk) begin
      if (!i_wrstn) begin
         state_r <= WAIT_VS;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Frame sequencing, FIFO push selection and flag events
   always_comb begin
      state_next_s = state_r;
      fifo_push_s  = 1'b0;
      fifo_wdata_s = pend_data_r;
      fifo_wlast_s = pend_last_r;
      pend_push_s  = 1'b0;
      ovf_set_s    = 1'b0;
      ferr_set_s   = 1'b0;
      case (state_r)
         WAIT_VS: begin
            if (vs_rise_s) begin
               state_next_s = ARM;
            end else begin
               state_next_s = WAIT_VS;
            end
         end
         ARM: begin
            if (vs_fall_s) begin
               state_next_s = ACTIVE;
            end else begin
               state_next_s = ARM;
            end
         end
         ACTIVE: begin
            if (pend_valid_r) begin
               if (push_ok_s) begin
                  fifo_push_s = 1'b1;
                  pend_push_s = 1'b1;
                  if (pend_last_r) begin
                     // frame closed cleanly; a coincident vsync already starts the next one
                     state_next_s = vs_rise_s ? ARM : DONE;
                  end else if (vs_rise_s) begin
                     ferr_set_s   = 1'b1;
                     state_next_s = FLUSH;
                  end else begin
                     state_next_s = ACTIVE;
                  end
               end else begin
                  ovf_set_s    = 1'b1;
                  state_next_s = FLUSH;
               end
            end else if (vs_rise_s) begin
               // nothing went downstream yet, so there is no frame to close
               if (pushed_any_r) begin
                  ferr_set_s   = 1'b1;
                  state_next_s = FLUSH;
               end else begin
                  state_next_s = ARM;
               end
            end else begin
               state_next_s = ACTIVE;
            end
         end
         FLUSH: begin
            fifo_wdata_s = {DATA_WIDTH{1'b0}};
            fifo_wlast_s = 1'b1;
            if (push_ok_s) begin
               fifo_push_s  = 1'b1;
               state_next_s = DONE;
            end else begin
               state_next_s = FLUSH;
            end
         end
         DONE: begin
            if (vs_rise_s) begin
               state_next_s = ARM;
            end else begin
               state_next_s = DONE;
            end
         end
         default: begin
            state_next_s = WAIT_VS;
         end
      endcase
   end

   // Next FIFO occupancy and the entry that will sit at the head afterwards
   always_comb begin
      count_next_s = count_r + CNT_W'(fifo_push_s) - CNT_W'(pop_s);
      rd_next_s    = rd_ptr_r + PTR_W'(pop_s);
      // an entry written this cycle into the new head slot bypasses the array
      if (fifo_push_s && (wr_ptr_r == rd_next_s)) begin
         head_s = {fifo_wlast_s, fifo_wdata_s};
      end else begin
         head_s = mem_r[rd_next_s];
      end
   end

   // FIFO storage; contents are meaningless once the pointers are reset
   always_ff @(posedge i_wclk) begin
      if (fifo_push_s) begin
         mem_r[wr_ptr_r] <= {fifo_wlast_s, fifo_wdata_s};
      end
   end

   // FIFO pointers and registered AXI-Stream outputs
   always_ff @(posedge i_wclk) begin
      if (!i_wrstn) begin
         wr_ptr_r    <= {PTR_W{1'b0}};
         rd_ptr_r    <= {PTR_W{1'b0}};
         count_r     <= {CNT_W{1'b0}};
         o_m_valid_r <= 1'b0;
         o_m_data_r  <= {DATA_WIDTH{1'b0}};
         o_m_last_r  <= 1'b0;
      end else begin
         wr_ptr_r    <= wr_ptr_r + PTR_W'(fifo_push_s);
         rd_ptr_r    <= rd_next_s;
         count_r     <= count_next_s;
         o_m_valid_r <= (count_next_s != {CNT_W{1'b0}});
         // head only moves on a pop or when an empty FIFO gets its first entry
         if (count_next_s != {CNT_W{1'b0}}) begin
            {o_m_last_r, o_m_data_r} <= head_s;
         end
      end
   end

   // Sticky error flags; a set in the same cycle as a clear wins
   always_ff @(posedge i_wclk) begin
      if (!i_wrstn) begin
         overflow_r  <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         if (ovf_set_s) begin
            overflow_r <= 1'b1;
         end else if (i_clr_flags) begin
            overflow_r <= 1'b0;
         end
         if (ferr_set_s) begin
            frame_err_r <= 1'b1;
         end else if (i_clr_flags) begin
            frame_err_r <= 1'b0;
         end
      end
   end

   assign o_m_valid   = o_m_valid_r;
   assign o_m_data    = o_m_data_r;
   assign o_m_last    = o_m_last_r;
   assign o_overflow  = overflow_r;
   assign o_frame_err = frame_err_r;

endmodule

// File: tb/tb_dvp_stream_capture.sv
// -----------------------------------------------------------------------------
// tb_dvp_stream_capture
//
// Scoreboard bench for dvp_stream_capture with a 4x2 frame and a 4-entry FIFO.
// The stimulus side pushes the beats it expects into a queue as it drives the
// camera bus; a monitor on the falling clock edge pops and compares every
// accepted AXI-Stream beat and checks that a stalled beat holds still.
// -----------------------------------------------------------------------------
module tb_dvp_stream_capture;

   localparam int W = 4;
   localparam int H = 2;
   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        vsync;
   logic        href;
   logic        pix_en;
   logic [7:0]  pdata;
   logic        m_valid;
   logic        m_ready;
   logic [11:0] m_data;
   logic        m_last;
   logic        overflow;
   logic        frame_err;
   logic        clr_flags;
`ifdef DVP_TEST_PATTERN_EN
   logic        tp_sel;
`endif

   int          total = 0;
   int          bad = 0;
   int          beats = 0;
   int          frame_pix = 0;
   int          exp_limit = 1000;
   int          beats_at_start = 0;
   bit          use_fixed = 1'b0;
   bit          tp_on = 1'b0;
   logic [12:0] exp_q [$];
   logic [12:0] want_beat;
   logic        stall_seen = 1'b0;
   logic [12:0] stall_beat = 13'h0000;

   always #5 clk = ~clk;

   dvp_stream_capture #(
      .FRAME_WIDTH (W),
      .FRAME_HEIGHT(H),
      .DATA_WIDTH  (12),
      .FIFO_DEPTH  (D)
   ) dut (
      .i_wclk     (clk),
      .i_wrstn    (rstn),
      .i_vsync    (vsync),
      .i_href     (href),
      .i_pix_en   (pix_en),
      .i_pdata    (pdata),
`ifdef DVP_TEST_PATTERN_EN
      .i_tp_sel   (tp_sel),
`endif
      .o_m_valid  (m_valid),
      .i_m_ready  (m_ready),
      .o_m_data   (m_data),
      .o_m_last   (m_last),
      .o_overflow (overflow),
      .o_frame_err(frame_err),
      .i_clr_flags(clr_flags)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, want, $time);
      end
   endtask

   function automatic logic [11:0] bar_rgb(input int k);
      case ((k * 8) / W)
         0:       bar_rgb = 12'hFFF;
         1:       bar_rgb = 12'hFF0;
         2:       bar_rgb = 12'h0FF;
         3:       bar_rgb = 12'h0F0;
         4:       bar_rgb = 12'hF0F;
         5:       bar_rgb = 12'hF00;
         6:       bar_rgb = 12'h00F;
         default: bar_rgb = 12'h000;
      endcase
   endfunction

   // Beat monitor: pop-and-compare on every accepted beat, hold check on stalls
   always @(negedge clk) begin
      if (!rstn) begin
         stall_seen = 1'b0;
      end else begin
         if (stall_seen) begin
            check("hold_valid", 32'(m_valid), 32'd1);
            check("hold_beat", 32'({m_last, m_data}), 32'(stall_beat));
         end
         if (m_valid && m_ready) begin
            beats++;
            check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               want_beat = exp_q.pop_front();
               check("beat_last", 32'(m_last), 32'(want_beat[12]));
               check("beat_data", 32'(m_data), 32'(want_beat[11:0]));
            end
         end
         stall_seen = m_valid && !m_ready;
         stall_beat = {m_last, m_data};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic vs_pulse();
      vsync = 1'b1;
      repeat (3) tick();
      vsync = 1'b0;
      repeat (3) tick();
   endtask

   task automatic start_frame();
      frame_pix = 0;
      beats_at_start = beats;
      vs_pulse();
   endtask

   // Two bytes for one pixel; the expected beat is queued if it should survive
   task automatic send_pix(input int row, input int k);
      logic [11:0] px;
      logic [7:0]  b0;
      logic [12:0] beat;
      if (use_fixed) begin
         px = 12'hABC;
         b0 = 8'h0A;
      end else begin
         px = 12'($urandom);
         b0 = {4'($urandom), px[11:8]};
      end
      beat = {(row == H - 1) && (k == W - 1), (tp_on ? bar_rgb(k) : px)};
      pix_en = 1'b1;
      pdata  = b0;
      tick();
      pdata  = px[7:0];
      tick();
      pix_en = 1'b0;
      pdata  = 8'h00;
      if (k < W) begin
         if (frame_pix < exp_limit) begin
            exp_q.push_back(beat);
         end
         frame_pix++;
      end
   endtask

   task automatic drive_line(input int row, input int npix);
      href = 1'b1;
      tick();
      for (int k = 0; k < npix; k++) begin
         send_pix(row, k);
      end
      href = 1'b0;
      repeat (2) tick();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0) && (n < 200)) begin
         tick();
         n++;
      end
      repeat (4) tick();
      check("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic full_frame(input int npix, input string tag);
      start_frame();
      for (int r = 0; r < H; r++) begin
         drive_line(r, npix);
      end
      drain();
      check(tag, 32'(beats - beats_at_start), 32'(W * H));
   endtask

   initial begin
      rstn      = 1'b0;
      vsync     = 1'b0;
      href      = 1'b0;
      pix_en    = 1'b0;
      pdata     = 8'h00;
      m_ready   = 1'b1;
      clr_flags = 1'b0;
`ifdef DVP_TEST_PATTERN_EN
      tp_sel    = 1'b0;
`endif
      repeat (3) tick();
      check("rst_valid", 32'(m_valid), 32'd0);
      check("rst_data", 32'(m_data), 32'd0);
      check("rst_last", 32'(m_last), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      rstn = 1'b1;
      repeat (2) tick();

      // nominal frame with the fixed 0x0A,0xBC byte pair
      use_fixed = 1'b1;
      full_frame(W, "nominal_beats");
      use_fixed = 1'b0;
      check("nominal_overflow", 32'(overflow), 32'd0);
      check("nominal_frame_err", 32'(frame_err), 32'd0);

      // random data, then over-long lines whose extra pixels must vanish
      full_frame(W, "random_beats");
      full_frame(W + 2, "long_line_beats");

      // short frame: 5 of 8 pixels, then vsync closes it with a filler beat
      start_frame();
      drive_line(0, W);
      drive_line(1, 1);
      repeat (3) tick();
      exp_q.push_back(13'h1000);
      vs_pulse();
      drain();
      check("short_beats", 32'(beats - beats_at_start), 32'd6);
      check("short_frame_err", 32'(frame_err), 32'd1);
      check("short_overflow", 32'(overflow), 32'd0);
      full_frame(W, "after_short_beats");
      check("frame_err_sticky", 32'(frame_err), 32'd1);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      tick();
      check("clr_frame_err", 32'(frame_err), 32'd0);

      // backpressure after two beats: pixel 7 overflows, filler closes frame
      exp_limit = 6;
      start_frame();
      href = 1'b1;
      tick();
      send_pix(0, 0);
      send_pix(0, 1);
      repeat (4) tick();
      m_ready = 1'b0;
      send_pix(0, 2);
      send_pix(0, 3);
      href = 1'b0;
      repeat (2) tick();
      drive_line(1, W);
      exp_q.push_back(13'h1000);
      repeat (3) tick();
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_fifo_valid", 32'(m_valid), 32'd1);
      check("ovf_pending", 32'(exp_q.size()), 32'd5);
      m_ready = 1'b1;
      drain();
      exp_limit = 1000;
      check("ovf_beats", 32'(beats - beats_at_start), 32'd7);
      check("ovf_frame_err", 32'(frame_err), 32'd0);
      check("ovf_sticky", 32'(overflow), 32'd1);

      // reset mid-frame with three pixels stuck in the FIFO
      exp_limit = 0;
      m_ready = 1'b0;
      start_frame();
      href = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         send_pix(0, k);
      end
      tick();
      rstn = 1'b0;
      href = 1'b0;
      repeat (2) tick();
      rstn = 1'b1;
      m_ready = 1'b1;
      tick();
      check("mid_rst_valid", 32'(m_valid), 32'd0);
      check("mid_rst_data", 32'(m_data), 32'd0);
      check("mid_rst_last", 32'(m_last), 32'd0);
      check("mid_rst_overflow", 32'(overflow), 32'd0);
      // bytes with vsync held low are not a frame
      beats_at_start = beats;
      drive_line(0, W);
      drive_line(1, W);
      repeat (10) tick();
      check("no_vsync_beats", 32'(beats - beats_at_start), 32'd0);
      exp_limit = 1000;
      full_frame(W, "post_rst_beats");

`ifdef DVP_TEST_PATTERN_EN
      tp_sel = 1'b1;
      tp_on  = 1'b1;
      full_frame(W, "pattern_beats");
      tp_sel = 1'b0;
      tp_on  = 1'b0;
      full_frame(W, "camera_again_beats");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
